// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one byte-wide RAM port between instruction fetch (IF) and the
//   load/store buffer (LSB). Multi-byte accesses are serialised one byte per
//   cycle. LSB wins ties. Each requester has one pending slot. A ROB rollback
//   flushes speculative reads but never touches stores.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_request_in/if_address_in   4-byte fetch request pulse + byte address
//   if_ready_out/if_data_out      fetch done pulse + little-endian word
//   lsb_request_in, lsb_rw_in,    load/store request pulse, 1=store,
//   lsb_address_in, lsb_goal_in,  byte address, size (1/2/else 4 bytes),
//   lsb_data_in                   store data
//   lsb_ready_out/lsb_data_out    done pulse + zero-extended load data
//   rob_rollback_in               flush of speculative work
//   io_buffer_full_in             UART buffer full (stalls IO-space writes)
//   ram_din_in/ram_dout_out/      RAM read data (one-cycle latency), write
//   ram_addr_out/ram_wr_out       data, byte address, write enable
module ram_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_request_in,
    input  logic [31:0] if_address_in,
    output logic        if_ready_out,
    output logic [31:0] if_data_out,
    input  logic        lsb_request_in,
    input  logic        lsb_rw_in,
    input  logic [31:0] lsb_address_in,
    input  logic [2:0]  lsb_goal_in,
    input  logic [31:0] lsb_data_in,
    output logic        lsb_ready_out,
    output logic [31:0] lsb_data_out,
    input  logic        rob_rollback_in,
    input  logic        io_buffer_full_in,
    input  logic [7:0]  ram_din_in,
    output logic [7:0]  ram_dout_out,
    output logic [31:0] ram_addr_out,
    output logic        ram_wr_out
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic        owner_q, owner_d;          // 1 = LSB, 0 = IF
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] data_q, data_d;
    logic        if_rdy_q, if_rdy_d;
    logic        lsb_rdy_q, lsb_rdy_d;
    logic        if_pend_q, if_pend_d;
    logic [31:0] if_paddr_q, if_paddr_d;
    logic        lsb_pend_q, lsb_pend_d;
    logic        lsb_prw_q, lsb_prw_d;
    logic [31:0] lsb_paddr_q, lsb_paddr_d;
    logic [2:0]  lsb_pgoal_q, lsb_pgoal_d;
    logic [31:0] lsb_pdata_q, lsb_pdata_d;

    logic        busy, if_acc, lsb_acc, if_have, lsb_have, stall, wr;
    logic [31:0] cur_addr, addr;
    logic [7:0]  dout;
    logic [1:0]  bidx;

    always_comb begin
        busy    = (state_q != IDLE);
        // A new pulse is taken only if that requester has nothing live;
        // speculative reads pulsing during a rollback are dropped.
        if_acc  = if_request_in && !if_pend_q && !(busy && !owner_q) && !rob_rollback_in;
        lsb_acc = lsb_request_in && !lsb_pend_q && !(busy && owner_q)
                  && !(rob_rollback_in && !lsb_rw_in);

        // Slot registers double as the "effective request" for this cycle.
        if_paddr_d  = if_paddr_q;
        lsb_prw_d   = lsb_prw_q;
        lsb_paddr_d = lsb_paddr_q;
        lsb_pgoal_d = lsb_pgoal_q;
        lsb_pdata_d = lsb_pdata_q;
        if (if_acc) if_paddr_d = if_address_in;
        if (lsb_acc) begin
            lsb_prw_d   = lsb_rw_in;
            lsb_paddr_d = lsb_address_in;
            lsb_pgoal_d = lsb_goal_in;
            lsb_pdata_d = lsb_data_in;
        end
        if_have  = (if_pend_q && !rob_rollback_in) || if_acc;
        lsb_have = (lsb_pend_q && !(rob_rollback_in && !lsb_prw_q)) || lsb_acc;

        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        owner_d    = owner_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        data_d     = data_q;
        if_rdy_d   = 1'b0;
        lsb_rdy_d  = 1'b0;
        if_pend_d  = if_have;
        lsb_pend_d = lsb_have;
        addr       = 32'd0;
        wr         = 1'b0;
        dout       = 8'd0;
        cur_addr   = base_q + {29'd0, cnt_q};
        bidx       = cnt_q[1:0] - 2'd1;
        stall      = io_buffer_full_in && (cur_addr[31:16] == 16'h0003);

        case (state_q)
            IDLE: begin
                if (lsb_have) begin
                    owner_d    = 1'b1;
                    base_d     = lsb_paddr_d;
                    wdata_d    = lsb_pdata_d;
                    len_d      = (lsb_pgoal_d == 3'd1) ? 3'd1 :
                                 (lsb_pgoal_d == 3'd2) ? 3'd2 : 3'd4;
                    state_d    = lsb_prw_d ? WRITE : READ;
                    cnt_d      = 3'd0;
                    buf_d      = 32'd0;
                    lsb_pend_d = 1'b0;
                end else if (if_have) begin
                    owner_d   = 1'b0;
                    base_d    = if_paddr_d;
                    len_d     = 3'd4;
                    state_d   = READ;
                    cnt_d     = 3'd0;
                    buf_d     = 32'd0;
                    if_pend_d = 1'b0;
                end
            end
            READ: begin
                // Address for byte cnt goes out while cnt < len; the RAM
                // returns it a cycle later, so byte cnt-1 is captured now.
                if (cnt_q < len_q) addr = cur_addr;
                if (rob_rollback_in) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != 3'd0) buf_d[{bidx, 3'b000} +: 8] = ram_din_in;
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                        data_d  = buf_d;
                        if (owner_q) lsb_rdy_d = 1'b1;
                        else         if_rdy_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            WRITE: begin
                addr = cur_addr;
                dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                wr   = !stall;
                if (!stall) begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d   = IDLE;
                        data_d    = 32'd0;
                        lsb_rdy_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            base_q      <= 32'd0;
            owner_q     <= 1'b0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            data_q      <= 32'd0;
            if_rdy_q    <= 1'b0;
            lsb_rdy_q   <= 1'b0;
            if_pend_q   <= 1'b0;
            if_paddr_q  <= 32'd0;
            lsb_pend_q  <= 1'b0;
            lsb_prw_q   <= 1'b0;
            lsb_paddr_q <= 32'd0;
            lsb_pgoal_q <= 3'd0;
            lsb_pdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            owner_q     <= owner_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            data_q      <= data_d;
            if_rdy_q    <= if_rdy_d;
            lsb_rdy_q   <= lsb_rdy_d;
            if_pend_q   <= if_pend_d;
            if_paddr_q  <= if_paddr_d;
            lsb_pend_q  <= lsb_pend_d;
            lsb_prw_q   <= lsb_prw_d;
            lsb_paddr_q <= lsb_paddr_d;
            lsb_pgoal_q <= lsb_pgoal_d;
            lsb_pdata_q <= lsb_pdata_d;
        end
    end

    // Outputs are forced quiet while reset is held, even mid-transaction.
    assign ram_addr_out  = rst ? 32'd0 : addr;
    assign ram_wr_out    = rst ? 1'b0  : wr;
    assign ram_dout_out  = rst ? 8'd0  : dout;
    assign if_ready_out  = if_rdy_q && !rst;
    assign lsb_ready_out = lsb_rdy_q && !rst;
    assign if_data_out   = (if_rdy_q && !rst) ? data_q : 32'd0;
    assign lsb_data_out  = (lsb_rdy_q && !rst) ? data_q : 32'd0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: byte RAM model with one-cycle read latency,
// table of single transactions, hand-written contention/stall/rollback/reset
// sequences, and a ready-pulse scoreboard.
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_request_in, lsb_request_in, lsb_rw_in;
    logic [31:0] if_address_in, lsb_address_in, lsb_data_in;
    logic [2:0]  lsb_goal_in;
    logic        rob_rollback_in, io_buffer_full_in;
    logic [7:0]  ram_din_in = 8'd0;
    logic        if_ready_out, lsb_ready_out, ram_wr_out;
    logic [31:0] if_data_out, lsb_data_out, ram_addr_out;
    logic [7:0]  ram_dout_out;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_request_in(if_request_in), .if_address_in(if_address_in),
        .if_ready_out(if_ready_out), .if_data_out(if_data_out),
        .lsb_request_in(lsb_request_in), .lsb_rw_in(lsb_rw_in),
        .lsb_address_in(lsb_address_in), .lsb_goal_in(lsb_goal_in),
        .lsb_data_in(lsb_data_in), .lsb_ready_out(lsb_ready_out),
        .lsb_data_out(lsb_data_out), .rob_rollback_in(rob_rollback_in),
        .io_buffer_full_in(io_buffer_full_in), .ram_din_in(ram_din_in),
        .ram_dout_out(ram_dout_out), .ram_addr_out(ram_addr_out),
        .ram_wr_out(ram_wr_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, want);
        end
    endtask

    // RAM model: untouched bytes read as their address low byte, with a few
    // preset locations; written bytes are kept in an overlay.
    function automatic logic [11:0] midx(input logic [31:0] a);
        return {(a[17:16] != 2'b00), a[12], a[9:0]};
    endfunction
    function automatic logic [7:0] seed(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h1002: return 8'h00;
            32'h1003: return 8'h00;
            32'h0020: return 8'hFF;
            default:  return a[7:0];
        endcase
    endfunction
    logic [7:0] wmem [4096];
    bit         wval [4096];
    always @(posedge clk) begin
        if (ram_wr_out) begin
            wmem[midx(ram_addr_out)] <= ram_dout_out;
            wval[midx(ram_addr_out)] <= 1'b1;
        end
        ram_din_in <= wval[midx(ram_addr_out)] ? wmem[midx(ram_addr_out)] : seed(ram_addr_out);
    end

    // Scoreboard of expected ready pulses, in completion order.
    typedef struct {bit lsb; logic [31:0] data; int cyc;} exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (if_ready_out || lsb_ready_out) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready @cycle %0d: if=%0b lsb=%0b, expected no pulse",
                         cyc, if_ready_out, lsb_ready_out);
            end else begin
                mon_e = sb.pop_front();
                chk("ready_owner", {31'd0, lsb_ready_out}, {31'd0, mon_e.lsb});
                chk("ready_excl", {31'd0, if_ready_out & lsb_ready_out}, 32'd0);
                chk("ready_cycle", cyc, mon_e.cyc);
                chk("ready_data", mon_e.lsb ? lsb_data_out : if_data_out, mon_e.data);
            end
        end
    end

    task automatic set_if(input logic [31:0] a);
        if_request_in = 1'b1;
        if_address_in = a;
    endtask
    task automatic set_lsb(input logic rw, input logic [31:0] a, input logic [2:0] g,
                           input logic [31:0] d);
        lsb_request_in = 1'b1;
        lsb_rw_in      = rw;
        lsb_address_in = a;
        lsb_goal_in    = g;
        lsb_data_in    = d;
    endtask
    task automatic clr_req();
        if_request_in  = 1'b0;
        lsb_request_in = 1'b0;
    endtask
    task automatic push(input bit lsb, input logic [31:0] d, input int c);
        exp_t e;
        e.lsb = lsb; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask
    task automatic wait_drain(input int bound);
        int k = 0;
        while (sb.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("drain", sb.size(), 32'd0);
        sb.delete();
    endtask

    typedef struct {
        bit          lsb;
        bit          rw;
        logic [31:0] addr;
        logic [2:0]  goal;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;
    vec_t tbl [14];

    // One isolated transaction issued from IDLE; ready is expected N+2
    // cycles later for reads and N+1 for stores.
    task automatic run_vec(input vec_t v);
        int c, n;
        @(negedge clk);
        c = cyc;
        if (v.lsb) set_lsb(v.rw, v.addr, v.goal, v.wdata);
        else       set_if(v.addr);
        n = !v.lsb ? 4 : (v.goal == 3'd1) ? 1 : (v.goal == 3'd2) ? 2 : 4;
        push(v.lsb, v.exp_data, c + n + (v.rw ? 1 : 2));
        @(negedge clk);
        clr_req();
        wait_drain(20);
    endtask

    initial begin
        int c;
        vec_t v;
        tbl[0]  = '{0, 0, 32'h0000_0240, 3'd4, 32'h0,         32'h4342_4140};
        tbl[1]  = '{0, 0, 32'h0000_1000, 3'd4, 32'h0,         32'h0000_0513};
        tbl[2]  = '{1, 0, 32'h0000_0025, 3'd1, 32'h0,         32'h0000_0025};
        tbl[3]  = '{1, 0, 32'h0000_0032, 3'd2, 32'h0,         32'h0000_3332};
        tbl[4]  = '{1, 0, 32'h0000_0084, 3'd4, 32'h0,         32'h8786_8584};
        tbl[5]  = '{1, 0, 32'h0000_0090, 3'd0, 32'h0,         32'h9392_9190};
        tbl[6]  = '{1, 0, 32'h0000_00A0, 3'd7, 32'h0,         32'hA3A2_A1A0};
        tbl[7]  = '{1, 1, 32'h0000_0300, 3'd4, 32'hDEAD_BEEF, 32'h0};
        tbl[8]  = '{1, 0, 32'h0000_0300, 3'd4, 32'h0,         32'hDEAD_BEEF};
        tbl[9]  = '{1, 1, 32'h0000_0310, 3'd1, 32'h1122_3344, 32'h0};
        tbl[10] = '{0, 0, 32'h0000_0310, 3'd4, 32'h0,         32'h1312_1144};
        tbl[11] = '{1, 1, 32'h0000_0322, 3'd2, 32'h5566_7788, 32'h0};
        tbl[12] = '{1, 0, 32'h0000_0320, 3'd4, 32'h0,         32'h7788_2120};
        tbl[13] = '{0, 0, 32'h0000_00FE, 3'd4, 32'h0,         32'h0100_FFFE};

        rst = 1'b1;
        if_request_in = 0; if_address_in = 0;
        lsb_request_in = 0; lsb_rw_in = 0; lsb_address_in = 0; lsb_goal_in = 0; lsb_data_in = 0;
        rob_rollback_in = 0; io_buffer_full_in = 0;

        // Reset state; requests during reset must be ignored.
        repeat (3) @(negedge clk);
        chk("rst_addr", ram_addr_out, 32'd0);
        chk("rst_wr", {31'd0, ram_wr_out}, 32'd0);
        chk("rst_dout", {24'd0, ram_dout_out}, 32'd0);
        chk("rst_if_rdy", {31'd0, if_ready_out}, 32'd0);
        chk("rst_lsb_rdy", {31'd0, lsb_ready_out}, 32'd0);
        chk("rst_if_data", if_data_out, 32'd0);
        chk("rst_lsb_data", lsb_data_out, 32'd0);
        set_lsb(0, 32'h20, 3'd1, 0);
        set_if(32'h1000);
        @(negedge clk);
        clr_req();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_rst", ram_addr_out, 32'd0);
        end

        for (int i = 0; i < 14; i++) run_vec(tbl[i]);

        // IF read 0x1000: address sequence then word 0x00000513.
        @(negedge clk); c = cyc;
        set_if(32'h1000);
        push(0, 32'h0000_0513, c + 6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) clr_req();
            chk("if_rd_addr", ram_addr_out, 32'h1000 + i);
            chk("if_rd_wr", {31'd0, ram_wr_out}, 32'd0);
        end
        repeat (2) @(negedge clk);
        chk("rdy_cycle_addr", ram_addr_out, 32'd0);
        wait_drain(20);

        // Simultaneous IF and LSB: LSB first, IF starts right after ready.
        @(negedge clk); c = cyc;
        set_lsb(0, 32'h20, 3'd1, 0);
        set_if(32'h1000);
        push(1, 32'h0000_00FF, c + 3);
        push(0, 32'h0000_0513, c + 9);
        @(negedge clk); clr_req();
        chk("prio_lsb_addr", ram_addr_out, 32'h20);
        repeat (2) @(negedge clk);
        chk("prio_rdy_quiet", ram_addr_out, 32'd0);
        @(negedge clk);
        chk("prio_if_addr", ram_addr_out, 32'h1000);
        wait_drain(20);

        // Store goal=2 0xAABBCCDD to 0x100.
        @(negedge clk); c = cyc;
        set_lsb(1, 32'h100, 3'd2, 32'hAABB_CCDD);
        push(1, 32'h0, c + 3);
        @(negedge clk); clr_req();
        chk("st_wr0", {31'd0, ram_wr_out}, 32'd1);
        chk("st_addr0", ram_addr_out, 32'h100);
        chk("st_dout0", {24'd0, ram_dout_out}, 32'hDD);
        @(negedge clk);
        chk("st_wr1", {31'd0, ram_wr_out}, 32'd1);
        chk("st_addr1", ram_addr_out, 32'h101);
        chk("st_dout1", {24'd0, ram_dout_out}, 32'hCC);
        @(negedge clk);
        chk("st_rdy_wr", {31'd0, ram_wr_out}, 32'd0);
        wait_drain(20);

        // IO write stalled for 3 cycles by a full UART buffer.
        @(negedge clk); c = cyc;
        set_lsb(1, 32'h3_0000, 3'd1, 32'h1234_565A);
        io_buffer_full_in = 1'b1;
        push(1, 32'h0, c + 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) clr_req();
            chk("io_stall_wr", {31'd0, ram_wr_out}, 32'd0);
        end
        @(negedge clk);
        io_buffer_full_in = 1'b0;
        #1;
        chk("io_wr", {31'd0, ram_wr_out}, 32'd1);
        chk("io_addr", ram_addr_out, 32'h3_0000);
        chk("io_dout", {24'd0, ram_dout_out}, 32'h5A);
        wait_drain(20);

        // Rollback during IF byte 2 with a pending load: both discarded.
        @(negedge clk); c = cyc;
        set_if(32'h240);
        @(negedge clk); clr_req();
        set_lsb(0, 32'h25, 3'd1, 0);
        @(negedge clk); clr_req();
        @(negedge clk);
        chk("rb_byte2_addr", ram_addr_out, 32'h242);
        rob_rollback_in = 1'b1;
        @(negedge clk);
        rob_rollback_in = 1'b0;
        chk("rb_idle_addr", ram_addr_out, 32'd0);
        chk("rb_idle_wr", {31'd0, ram_wr_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rb_no_if_rdy", {31'd0, if_ready_out}, 32'd0);
            chk("rb_no_lsb_rdy", {31'd0, lsb_ready_out}, 32'd0);
            chk("rb_quiet_addr", ram_addr_out, 32'd0);
        end

        // Rollback during a store (with a pending IF): store completes, IF dropped.
        @(negedge clk); c = cyc;
        set_lsb(1, 32'h330, 3'd4, 32'h0102_0304);
        push(1, 32'h0, c + 5);
        @(negedge clk); clr_req();
        set_if(32'h240);
        @(negedge clk); clr_req();
        rob_rollback_in = 1'b1;
        chk("rbst_wr1", {31'd0, ram_wr_out}, 32'd1);
        chk("rbst_addr1", ram_addr_out, 32'h331);
        @(negedge clk);
        rob_rollback_in = 1'b0;
        chk("rbst_addr2", ram_addr_out, 32'h332);
        repeat (3) begin
            @(negedge clk);
            if (cyc >= c + 5) chk("rbst_if_dropped", ram_addr_out, 32'd0);
        end
        wait_drain(20);
        v = '{1, 0, 32'h330, 3'd4, 32'h0, 32'h0102_0304};
        run_vec(v);

        // Reset mid-transaction: outputs quiet, no ready, requests ignored.
        @(negedge clk); c = cyc;
        set_if(32'h240);
        @(negedge clk); clr_req();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_addr", ram_addr_out, 32'd0);
        chk("midrst_wr", {31'd0, ram_wr_out}, 32'd0);
        @(negedge clk);
        set_lsb(0, 32'h25, 3'd1, 0);
        @(negedge clk);
        clr_req();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_quiet", ram_addr_out, 32'd0);
            chk("midrst_no_rdy", {31'd0, if_ready_out | lsb_ready_out}, 32'd0);
        end

        // Rollback cycle: IF pulse dropped, store pulse accepted.
        @(negedge clk); c = cyc;
        set_if(32'h240);
        set_lsb(1, 32'h350, 3'd1, 32'h0000_0077);
        rob_rollback_in = 1'b1;
        push(1, 32'h0, c + 2);
        @(negedge clk);
        clr_req();
        rob_rollback_in = 1'b0;
        chk("rbcyc_wr", {31'd0, ram_wr_out}, 32'd1);
        chk("rbcyc_addr", ram_addr_out, 32'h350);
        chk("rbcyc_dout", {24'd0, ram_dout_out}, 32'h77);
        repeat (2) @(negedge clk);
        chk("rbcyc_if_dropped", ram_addr_out, 32'd0);
        wait_drain(20);

        // Second IF pulse while its own read is live is ignored.
        @(negedge clk); c = cyc;
        set_if(32'h240);
        push(0, 32'h4342_4140, c + 6);
        @(negedge clk); clr_req();
        @(negedge clk); set_if(32'h1000);
        @(negedge clk); clr_req();
        repeat (4) @(negedge clk);
        chk("dup_if_ignored", ram_addr_out, 32'd0);
        wait_drain(20);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
